// File: rtl/truth_table_checker.sv
// Sequential truth-table checker: sweeps every input vector of an external
// combinational block, compares each sampled output against a minterm/maxterm mask.
module truth_table_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [(1<<N_IN)-1:0]   term_mask,
    output logic [N_IN-1:0]        vec,
    input  logic                   dut_out,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [N_IN-1:0]        row_vec,
    output logic                   row_exp,
    output logic                   row_got,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN:0]          ones_count,
    output logic [N_IN:0]          mism_count,
    output logic [N_IN-1:0]        first_bad
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [N_IN-1:0]       vec_q, vec_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  mode_q, mode_d;
    logic [(1<<N_IN)-1:0]  mask_q, mask_d;
    logic                  row_exp_q, row_exp_d;
    logic                  row_got_q, row_got_d;
    logic [N_IN:0]         ones_q, ones_d;
    logic [N_IN:0]         mism_q, mism_d;
    logic [N_IN-1:0]       first_bad_q, first_bad_d;
    logic                  exp_bit;

    // NOTE: every always_comb output is given its hold value first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        wait_d      = wait_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        row_exp_d   = row_exp_q;
        row_got_d   = row_got_q;
        ones_d      = ones_q;
        mism_d      = mism_q;
        first_bad_d = first_bad_q;
        exp_bit     = mode_q ? ~mask_q[vec_q] : mask_q[vec_q];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    mask_d      = term_mask;
                    ones_d      = '0;
                    mism_d      = '0;
                    first_bad_d = '0;
                    vec_d       = '0;
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(SETTLE - 1)) begin
                    row_got_d = dut_out;
                    row_exp_d = exp_bit;
                    ones_d    = ones_q + (N_IN+1)'(dut_out);
                    if (dut_out != exp_bit) begin
                        mism_d = mism_q + (N_IN+1)'(1);
                        if (mism_q == '0) begin
                            first_bad_d = vec_q;
                        end
                    end
                    state_d = S_EMIT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_EMIT: begin
                // The last row ends the sweep instead of wrapping the index.
                if (row_ready) begin
                    if (vec_q == {N_IN{1'b1}}) begin
                        state_d = S_FIN;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        state_d = S_DRIVE;
                    end
                end
            end
            S_FIN: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            wait_q      <= '0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            row_exp_q   <= 1'b0;
            row_got_q   <= 1'b0;
            ones_q      <= '0;
            mism_q      <= '0;
            first_bad_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            wait_q      <= wait_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            row_exp_q   <= row_exp_d;
            row_got_q   <= row_got_d;
            ones_q      <= ones_d;
            mism_q      <= mism_d;
            first_bad_q <= first_bad_d;
        end
    end

    // Status outputs are decoded from the state register only: no path from row_ready.
    assign vec        = vec_q;
    assign row_vec    = vec_q;
    assign row_valid  = (state_q == S_EMIT);
    assign row_exp    = row_exp_q;
    assign row_got    = row_got_q;
    assign busy       = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign done       = (state_q == S_FIN);
    assign ones_count = ones_q;
    assign mism_count = mism_q;
    assign first_bad  = first_bad_q;

endmodule
